// File: rtl/parity_acc.sv
// Frame parity accumulator: XORs every word of a frame, counts the words with saturation,
// and presents the result until the consumer takes it.
module parity_acc #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter bit ODD   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_parity,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic cnt_full(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    if (clr) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            acc_d   = in_data;
            cnt_d   = CNT_W'(1);
            ovf_d   = 1'b0;
            state_d = in_last ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc_d = acc_q ^ in_data;
            cnt_d = sat_inc(cnt_q);
            if (cnt_full(cnt_q)) ovf_d = 1'b1;
            if (in_last) state_d = DONE;
          end
        end
        DONE: begin
          // Leaving DONE clears the result so IDLE always reads zero.
          if (out_ready) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = (state_q != DONE);
  assign out_valid  = (state_q == DONE);
  assign out_data   = acc_q;
  assign out_count  = cnt_q;
  assign out_ovf    = ovf_q;
  assign out_parity = (^acc_q) ^ ODD;

endmodule
